// File: rtl/bram_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : bram_port_arbiter
// Description : Round-robin two-requester arbiter for one 9-bit block-RAM port,
//               with tagged read return and a whole-RAM clear engine.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_arbiter #(
    parameter int                 ADDR_W   = 11,
    parameter int                 DATA_W   = 9,
    parameter logic [DATA_W-1:0]  FILL_VAL = '0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] DI0,
    input  logic [DATA_W-1:0] DI1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    input  logic              CLR_START,
    output logic              CLR_BUSY,
    output logic              CLR_DONE,
    output logic              RAM_EN,
    output logic              RAM_WE,
    output logic              RAM_SSR,
    output logic [ADDR_W-1:0] RAM_ADDR,
    output logic [DATA_W-1:0] RAM_DI,
    input  logic [DATA_W-1:0] RAM_DO
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_last = '1;

    state_t              r_state;
    logic                r_last;
    logic                r_rd_v;
    logic                r_rd_id;
    logic                r_rvalid0;
    logic                r_rvalid1;
    logic                r_clr_done;
    logic                r_ram_en;
    logic                r_ram_we;
    logic [ADDR_W-1:0]   r_ram_addr;
    logic [DATA_W-1:0]   r_ram_di;

    logic                w_arb_ok;
    logic                w_gnt0;
    logic                w_gnt1;

    // Reset gating keeps the combinational grants low while RST_N is asserted.
    assign w_arb_ok = RST_N && (r_state == ST_ARB) && !CLR_START;
    assign w_gnt0   = w_arb_ok && REQ0 && (!REQ1 || r_last);
    assign w_gnt1   = w_arb_ok && REQ1 && (!REQ0 || !r_last);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state    <= ST_ARB;
            r_last     <= 1'b1;
            r_rd_v     <= 1'b0;
            r_rd_id    <= 1'b0;
            r_rvalid0  <= 1'b0;
            r_rvalid1  <= 1'b0;
            r_clr_done <= 1'b0;
            r_ram_en   <= 1'b0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_di   <= '0;
        end else begin
            r_clr_done <= 1'b0;
            r_rd_v     <= (w_gnt0 && !WE0) || (w_gnt1 && !WE1);
            r_rd_id    <= w_gnt1;
            r_rvalid0  <= r_rd_v && !r_rd_id;
            r_rvalid1  <= r_rd_v && r_rd_id;
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end

            if (r_state == ST_ARB) begin
                if (CLR_START) begin
                    r_state    <= ST_CLEAR;
                    r_ram_en   <= 1'b1;
                    r_ram_we   <= 1'b1;
                    r_ram_addr <= '0;
                    r_ram_di   <= FILL_VAL;
                end else if (w_gnt0) begin
                    r_ram_en   <= 1'b1;
                    r_ram_we   <= WE0;
                    r_ram_addr <= ADDR0;
                    r_ram_di   <= DI0;
                end else if (w_gnt1) begin
                    r_ram_en   <= 1'b1;
                    r_ram_we   <= WE1;
                    r_ram_addr <= ADDR1;
                    r_ram_di   <= DI1;
                end else begin
                    r_ram_en   <= 1'b0;
                    r_ram_we   <= 1'b0;
                    r_ram_addr <= '0;
                    r_ram_di   <= '0;
                end
            end else begin
                // The RAM address register doubles as the sweep counter.
                if (r_ram_addr == c_addr_last) begin
                    r_state    <= ST_ARB;
                    r_clr_done <= 1'b1;
                    r_ram_en   <= 1'b0;
                    r_ram_we   <= 1'b0;
                    r_ram_addr <= '0;
                    r_ram_di   <= '0;
                end else begin
                    r_ram_addr <= r_ram_addr + 1'b1;
                end
            end
        end
    end

    assign GNT0     = w_gnt0;
    assign GNT1     = w_gnt1;
    assign RVALID0  = r_rvalid0;
    assign RVALID1  = r_rvalid1;
    assign RDATA    = (r_rvalid0 || r_rvalid1) ? RAM_DO : '0;
    assign CLR_BUSY = (r_state == ST_CLEAR);
    assign CLR_DONE = r_clr_done;
    assign RAM_EN   = r_ram_en;
    assign RAM_WE   = r_ram_we;
    assign RAM_SSR  = 1'b0;
    assign RAM_ADDR = r_ram_addr;
    assign RAM_DI   = r_ram_di;

endmodule
`default_nettype wire

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one 9-bit port of a dual-port 16Kb block RAM (2048 x 8 data + 1 parity, the X_RAMB16_S4_S9 port B geometry) between two requesters.
- Arbitration is round-robin with a request/grant handshake; read data returns tagged to the requester that issued the read.
- A built-in clear engine sweeps the whole RAM to a fill value on command, with no requester involvement.
- Sits between the RAM primitive's port B pins and client logic; port A is untouched.

Parameters:
- ADDR_W, 11, RAM word address width; depth = 2**ADDR_W.
- DATA_W, 9, word width (bits [7:0] data, bit [8] parity).
- FILL_VAL, 9'h000, value written by the clear engine.

Ports:
- CLK  in  1  single clock; all logic on rising edge.
- RST_N  in  1  asynchronous active-low reset.
- REQ0 / REQ1  in  1  requester 0/1 access request, held until granted.
- WE0 / WE1  in  1  1 = write, 0 = read; qualified by REQx.
- ADDR0 / ADDR1  in  ADDR_W  requester address.
- DI0 / DI1  in  DATA_W  requester write data.
- GNT0 / GNT1  out  1  combinational; high = request accepted this cycle.
- RVALID0 / RVALID1  out  1  read data valid for requester 0/1.
- RDATA  out  DATA_W  read return data (shared, qualified by RVALIDx).
- CLR_START  in  1  start clear sweep (single-cycle pulse or level).
- CLR_BUSY  out  1  clear sweep in progress.
- CLR_DONE  out  1  one-cycle pulse when the sweep completes.
- RAM_EN  out  1  to RAM ENB.
- RAM_WE  out  1  to RAM WEB.
- RAM_SSR  out  1  to RAM SSRB; constant 0.
- RAM_ADDR  out  ADDR_W  to RAM ADDRB.
- RAM_DI  out  DATA_W  to RAM {DIPB,DIB}.
- RAM_DO  in  DATA_W  from RAM {DOPB,DOB}.

Behaviour:
- Reset: all outputs are 0; FSM = ARB; round-robin last-served = 1, so requester 0 wins the first tie. The read-tag pipeline and clear address are cleared. RAM_DO is ignored until a read is issued.
- FSM states ARB and CLEAR:
  - ARB -> CLEAR when CLR_START = 1 at a rising edge.
  - CLEAR -> ARB after the write to address DEPTH-1.
- Grant rules (ARB only, and only when CLR_START = 0):
  - Only one REQx high: GNTx = 1 in the same cycle.
  - Both high: grant the requester not served last; update last-served on every grant.
  - At most one GNT per cycle; GNT is never high in CLEAR or while CLR_START = 1 (clear beats requesters in the same cycle).
- Command timing: the request granted in cycle N is registered and driven on RAM_EN/RAM_WE/RAM_ADDR/RAM_DI in cycle N+1. RAM_EN = 0 in cycles with no command.
- Read latency: RAM captures at the end of N+1, RAM_DO is valid in N+2. In N+2, RVALIDx = 1 for the originating requester and RDATA = RAM_DO (passthrough).
- Write-grant behaviour: no RVALID; RAM output-register content after a write is don't-care.
- Back-to-back: one grant per cycle sustained, so the RAM is fully pipelined and reads return in issue order.
- Clear sweep:
  - Entering CLEAR asserts CLR_BUSY in the first CLEAR cycle.
  - Each CLEAR cycle drives RAM_EN = 1, RAM_WE = 1, RAM_DI = FILL_VAL, with RAM_ADDR stepping 0, 1, ..., DEPTH-1, one per cycle: 2048 write cycles at default.
  - In the cycle after the address DEPTH-1 write: CLR_BUSY = 0, CLR_DONE = 1 for one cycle, FSM = ARB, and grants may occur that same cycle.
  - The address counter must not wrap into a second sweep.
- CLR_START while in CLEAR is ignored; the sweep is not restarted.
- Reads granted before the clear began still complete: RVALID two cycles after the grant, even if that lands inside CLEAR.
- REQx dropped before a grant has no effect. Requesters must hold WE/ADDR/DI stable while REQx is high.
- Reset asserted mid-sweep or mid-read aborts immediately:
  - outputs return to 0, with no CLR_DONE and no pending RVALID;
  - after release, the FSM is in ARB;
  - RAM contents are left partially cleared.

Test Plan:
- Reset with REQ0 = REQ1 = 1 held -> after release, grants alternate GNT0, GNT1, GNT0, ... on consecutive cycles; RAM_EN = 1 every cycle from the second cycle on.
- Requester 0 writes 9'h1A5 to addr 0x123, then reads 0x123 -> RVALID0 = 1 with RDATA = 9'h1A5 exactly 2 cycles after the read GNT0; RVALID1 stays 0.
- Interleaved reads: R0 reads addr 5 (pre-written 9'h005) and R1 reads addr 6 (9'h006) on adjacent grants -> RVALID0/RDATA = 9'h005 then RVALID1/RDATA = 9'h006 on consecutive cycles.
- CLR_START together with REQ0 -> GNT0 = 0; CLR_BUSY high for exactly 2048 cycles with RAM_ADDR 0..2047; CLR_DONE pulses once; GNT0 rises in the CLR_DONE cycle; a later read of addr 0x7FF returns FILL_VAL.
- CLR_START pulsed again mid-sweep -> sweep length is still 2048 cycles with a single CLR_DONE.
- RST_N low at sweep address 100 -> all outputs go to 0 asynchronously, no CLR_DONE; after release, REQ1 alone gets GNT1 in the first cycle.
